// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/loader memory arbiter.
// State, requester encoding and default burst limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        LOCK = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

    localparam int MAX_BURST_DEF = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bundle of the arbiter.
// slave = arbiter view, master = surrounding system.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_hold;
    logic              cpu_valid;

    logic              ldr_req;
    logic              ldr_we;
    logic              ldr_lock;
    logic              ldr_done;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic              ldr_valid;

    logic [DATA_W-1:0] rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_lock, ldr_done,
        input  ldr_addr, ldr_wdata, mem_rdata,
        output cpu_gnt, cpu_stall, cpu_hold, cpu_valid,
        output ldr_gnt, ldr_valid, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_lock, ldr_done,
        output ldr_addr, ldr_wdata, mem_rdata,
        input  cpu_gnt, cpu_stall, cpu_hold, cpu_valid,
        input  ldr_gnt, ldr_valid, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker.
// prio_b_i selects the winner when both sides request.
module mem_arb_rr (
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic prio_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    assign gnt_a_o = req_a_i & (~req_b_i | ~prio_b_i);
    assign gnt_b_o = req_b_i & (~req_a_i |  prio_b_i);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one synchronous single-port memory between CPU and boot loader.
// BOOT holds the CPU, RUN alternates, LOCK gives the loader bounded bursts.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input logic         clk,
    input logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    state_t           state_q, state_d;
    owner_t           rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_vld_q;
    owner_t           rd_own_q;

    logic              rr_cpu, rr_ldr;
    logic              cpu_gnt, ldr_gnt;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    mem_arb_rr u_rr (
        .req_a_i  (bus.cpu_req),
        .req_b_i  (bus.ldr_req),
        .prio_b_i (rr_q == OWN_LDR),
        .gnt_a_o  (rr_cpu),
        .gnt_b_o  (rr_ldr)
    );

    always_comb begin
        cpu_gnt = 1'b0;
        ldr_gnt = 1'b0;
        unique case (state_q)
            BOOT: ldr_gnt = bus.ldr_req;
            RUN: begin
                cpu_gnt = rr_cpu;
                ldr_gnt = rr_ldr;
            end
            LOCK: ldr_gnt = bus.ldr_req;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        // rr_q names the side that wins the next contended cycle
        if (cpu_gnt) rr_d = OWN_LDR;
        if (ldr_gnt) rr_d = OWN_CPU;
        unique case (state_q)
            BOOT: if (bus.ldr_done) state_d = RUN;
            RUN: begin
                if (ldr_gnt && bus.ldr_lock) begin
                    state_d = LOCK;
                    cnt_d   = '0;
                end
            end
            LOCK: begin
                if (ldr_gnt && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                if (!bus.ldr_lock || (cnt_d == CNT_MAX && bus.cpu_req)) begin
                    state_d = RUN;
                    rr_d    = OWN_CPU;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            rr_q     <= OWN_CPU;
            cnt_q    <= '0;
            rd_vld_q <= 1'b0;
            rd_own_q <= OWN_CPU;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            rd_vld_q <= (cpu_gnt & ~bus.cpu_we) | (ldr_gnt & ~bus.ldr_we);
            rd_own_q <= ldr_gnt ? OWN_LDR : OWN_CPU;
        end
    end

    assign addr_mux  = ldr_gnt ? bus.ldr_addr  : bus.cpu_addr;
    assign wdata_mux = ldr_gnt ? bus.ldr_wdata : bus.cpu_wdata;

    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.ldr_gnt   = ldr_gnt;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;
    assign bus.cpu_hold  = (state_q == BOOT);
    assign bus.mem_en    = cpu_gnt | ldr_gnt;
    assign bus.mem_we    = (ldr_gnt & bus.ldr_we) | (cpu_gnt & bus.cpu_we);
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.cpu_valid = rd_vld_q & (rd_own_q == OWN_CPU);
    assign bus.ldr_valid = rd_vld_q & (rd_own_q == OWN_LDR);
    assign bus.rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM.
// Inputs change on the falling edge and are checked 1 ns later.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [7:0] mem [256];

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_arbiter #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .MAX_BURST (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 8'h00;
        bus.cpu_wdata = 8'h00;
        bus.ldr_req   = 1'b0;
        bus.ldr_we    = 1'b0;
        bus.ldr_lock  = 1'b0;
        bus.ldr_done  = 1'b0;
        bus.ldr_addr  = 8'h00;
        bus.ldr_wdata = 8'h00;
    endtask

    initial begin
        logic pc;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle();

        // reset: boot behaviour while rst_n low, read during reset dropped
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bus.ldr_req = 1'b1;
        #1;
        chk("rst_hold", bus.cpu_hold, 1);
        chk("rst_cgnt", bus.cpu_gnt, 0);
        chk("rst_lgnt", bus.ldr_gnt, 1);
        chk("rst_men", bus.mem_en, 1);
        chk("rst_stall", bus.cpu_stall, 1);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        chk("rst_lvld", bus.ldr_valid, 0);
        chk("rst_cvld", bus.cpu_valid, 0);
        @(negedge clk);
        #1;
        chk("rst_lvld_after", bus.ldr_valid, 0);
        chk("rst_men_idle", bus.mem_en, 0);

        // boot writes 0xA0..0xA3, lock ignored in BOOT
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle();
            bus.cpu_req   = 1'b1;
            bus.ldr_req   = 1'b1;
            bus.ldr_we    = 1'b1;
            bus.ldr_lock  = (i == 0);
            bus.ldr_done  = (i == 3);
            bus.ldr_addr  = 8'(i);
            bus.ldr_wdata = 8'(8'hA0 + i);
            #1;
            chk("boot_hold", bus.cpu_hold, 1);
            chk("boot_cgnt", bus.cpu_gnt, 0);
            chk("boot_lgnt", bus.ldr_gnt, 1);
            chk("boot_mwe", bus.mem_we, 1);
            chk("boot_maddr", bus.mem_addr, i);
        end
        @(negedge clk);
        idle();
        #1;
        chk("run_hold", bus.cpu_hold, 0);
        for (int i = 0; i < 4; i++) chk("boot_mem", mem[i], 8'hA0 + i);

        // contended reads alternate C,L,C,L,C,L
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            idle();
            bus.cpu_req  = 1'b1;
            bus.cpu_addr = 8'h00;
            bus.ldr_req  = 1'b1;
            bus.ldr_addr = 8'h01;
            #1;
            chk("alt_cgnt", bus.cpu_gnt, (k % 2 == 0));
            chk("alt_lgnt", bus.ldr_gnt, (k % 2 == 1));
            if (k > 0) begin
                pc = ((k - 1) % 2 == 0);
                chk("alt_cvld", bus.cpu_valid, pc);
                chk("alt_lvld", bus.ldr_valid, !pc);
                chk("alt_rdata", bus.rdata, pc ? 8'hA0 : 8'hA1);
            end
        end
        @(negedge clk);
        idle();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 8'h02;
        #1;
        chk("alt_last_lvld", bus.ldr_valid, 1);
        chk("alt_last_rdata", bus.rdata, 8'hA1);
        chk("solo_cgnt", bus.cpu_gnt, 1);

        // locked burst: 16 loader grants, then the CPU
        for (int j = 0; j < 17; j++) begin
            @(negedge clk);
            idle();
            bus.cpu_req  = 1'b1;
            bus.cpu_addr = 8'h03;
            bus.ldr_req  = 1'b1;
            bus.ldr_lock = 1'b1;
            bus.ldr_addr = 8'h03;
            #1;
            if (j == 0) begin
                chk("solo_cvld", bus.cpu_valid, 1);
                chk("solo_rdata", bus.rdata, 8'hA2);
            end
            chk("burst_lgnt", bus.ldr_gnt, (j < 16));
            chk("burst_cgnt", bus.cpu_gnt, (j == 16));
            chk("burst_stall", bus.cpu_stall, (j < 16));
        end

        // lock released after 3 grants
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            idle();
            bus.cpu_req  = 1'b1;
            bus.ldr_req  = 1'b1;
            bus.ldr_lock = 1'b1;
            #1;
            chk("rel_lgnt", bus.ldr_gnt, 1);
            chk("rel_cgnt", bus.cpu_gnt, 0);
        end
        @(negedge clk);
        idle();
        bus.cpu_req = 1'b1;
        #1;
        chk("rel_drop_cgnt", bus.cpu_gnt, 0);
        @(negedge clk);
        idle();
        bus.cpu_req = 1'b1;
        bus.ldr_req = 1'b1;
        #1;
        chk("rel_run_cgnt", bus.cpu_gnt, 1);
        chk("rel_run_lgnt", bus.ldr_gnt, 0);

        // CPU write 0x55 to 0x20 then read it back
        @(negedge clk);
        idle();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 8'h20;
        bus.cpu_wdata = 8'h55;
        #1;
        chk("wr_cgnt", bus.cpu_gnt, 1);
        chk("wr_mwe", bus.mem_we, 1);
        chk("wr_maddr", bus.mem_addr, 8'h20);
        @(negedge clk);
        idle();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 8'h20;
        #1;
        chk("rd_mwe", bus.mem_we, 0);
        chk("rd_men", bus.mem_en, 1);
        chk("wr_no_vld", bus.cpu_valid, 0);
        @(negedge clk);
        idle();
        #1;
        chk("rd_cvld", bus.cpu_valid, 1);
        chk("rd_lvld", bus.ldr_valid, 0);
        chk("rd_rdata", bus.rdata, 8'h55);
        chk("idle_men", bus.mem_en, 0);

        // reset lands on the edge after a CPU read grant
        @(negedge clk);
        idle();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 8'h10;
        rst_n        = 1'b0;
        #1;
        chk("mid_cgnt", bus.cpu_gnt, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_cvld", bus.cpu_valid, 0);
        chk("mid_hold", bus.cpu_hold, 1);
        chk("mid_cgnt_boot", bus.cpu_gnt, 0);
        chk("mid_stall", bus.cpu_stall, 1);
        @(negedge clk);
        idle();
        #1;
        chk("mid_cvld_after", bus.cpu_valid, 0);
        chk("mid_hold_after", bus.cpu_hold, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
